// File: rtl/fmap_maxpool_reader.sv
// 2x2 stride-2 signed max pooling over the conv-output feature-map RAM, streamed out on valid/ready.
// Optional build macro POOL_RELU_EN clamps negative pooled words to zero.
module fmap_maxpool_reader #(
  parameter int CH = 64,
  parameter int H  = 28,
  parameter int W  = 28,
  parameter int DW = 32,
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          reset_R,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr_a,
  output logic [AW-1:0] rd_addr_b,
  input  logic [DW-1:0] rd_data_a,
  input  logic [DW-1:0] rd_data_b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [7:0]    out_ch,
  output logic [7:0]    out_row,
  output logic [7:0]    out_col
);

  if ((H % 2) != 0 || (W % 2) != 0) begin : g_chk_even
    $error("fmap_maxpool_reader: H and W must be even");
  end
  if (longint'(CH) * longint'(H) * longint'(W) > (longint'(1) << AW)) begin : g_chk_addr
    $error("fmap_maxpool_reader: CH*H*W exceeds the AW-bit address space");
  end
  if (CH > 256 || H > 512 || W > 512) begin : g_chk_idx
    $error("fmap_maxpool_reader: indices do not fit the 8-bit index outputs");
  end

  typedef enum logic [2:0] {S_IDLE, S_RD_TOP, S_RD_BOT, S_CAP, S_OUT, S_DONE} state_t;

  localparam logic [7:0]    CH_LAST = 8'(CH - 1);
  localparam logic [7:0]    PR_LAST = 8'(H / 2 - 1);
  localparam logic [7:0]    PC_LAST = 8'(W / 2 - 1);
  localparam logic [AW-1:0] PLANE   = AW'(H * W);
  localparam logic [AW-1:0] ROW     = AW'(W);

  state_t        state_q, state_d;
  logic [7:0]    ch_q, ch_d, pr_q, pr_d, pc_q, pc_d;
  logic [DW-1:0] top_q, top_d, data_q, data_d;
  logic [7:0]    och_q, och_d, orow_q, orow_d, ocol_q, ocol_d;
  logic [AW-1:0] base;
  logic [DW-1:0] pooled;

  function automatic logic [DW-1:0] smax(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return ($signed(a) >= $signed(b)) ? a : b;
  endfunction

  // Top-left pixel of the current window: ch*H*W + (2*pr)*W + 2*pc
  assign base = AW'(ch_q) * PLANE + AW'({pr_q, 1'b0}) * ROW + AW'({pc_q, 1'b0});

  always_comb begin
    pooled = smax(top_q, smax(rd_data_a, rd_data_b));
`ifdef POOL_RELU_EN
    if (pooled[DW-1]) pooled = '0;
`endif
  end

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    pr_d      = pr_q;
    pc_d      = pc_q;
    top_d     = top_q;
    data_d    = data_q;
    och_d     = och_q;
    orow_d    = orow_q;
    ocol_d    = ocol_q;
    busy      = 1'b0;
    done      = 1'b0;
    rd_en     = 1'b0;
    out_valid = 1'b0;
    rd_addr_a = base;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RD_TOP;
      end
      S_RD_TOP: begin
        busy    = 1'b1;
        rd_en   = 1'b1;
        state_d = S_RD_BOT;
      end
      S_RD_BOT: begin
        busy      = 1'b1;
        rd_en     = 1'b1;
        rd_addr_a = base + ROW;
        top_d     = smax(rd_data_a, rd_data_b);
        state_d   = S_CAP;
      end
      S_CAP: begin
        busy    = 1'b1;
        data_d  = pooled;
        och_d   = ch_q;
        orow_d  = pr_q;
        ocol_d  = pc_q;
        state_d = S_OUT;
      end
      S_OUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          if (ch_q == CH_LAST && pr_q == PR_LAST && pc_q == PC_LAST) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RD_TOP;
            if (pc_q == PC_LAST) begin
              pc_d = '0;
              if (pr_q == PR_LAST) begin
                pr_d = '0;
                ch_d = ch_q + 8'd1;
              end else begin
                pr_d = pr_q + 8'd1;
              end
            end else begin
              pc_d = pc_q + 8'd1;
            end
          end
        end
      end
      S_DONE: begin
        // start is deliberately not looked at here
        done    = 1'b1;
        ch_d    = '0;
        pr_d    = '0;
        pc_d    = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rd_addr_b = rd_addr_a + AW'(1);
  assign out_data  = data_q;
  assign out_ch    = och_q;
  assign out_row   = orow_q;
  assign out_col   = ocol_q;

  always_ff @(posedge clk or posedge reset_R) begin
    if (reset_R) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      pr_q    <= '0;
      pc_q    <= '0;
      top_q   <= '0;
      data_q  <= '0;
      och_q   <= '0;
      orow_q  <= '0;
      ocol_q  <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      pr_q    <= pr_d;
      pc_q    <= pc_d;
      top_q   <= top_d;
      data_q  <= data_d;
      och_q   <= och_d;
      orow_q  <= orow_d;
      ocol_q  <= ocol_d;
    end
  end

endmodule
